// File: rtl/input_log_pkg.sv
// -----------------------------------------------------------------------------
// input_log_pkg
// Shared definitions for the input log uploader:
//   - log_rec_t     : one 64-bit log record {aux, joy, frame}; frame lands in
//                     the low bytes so byte 0 of the RAM word is frame[7:0]
//   - read_state_t  : states of the HPS read FSM
//   - HDR_BYTES     : size of the header in front of the records
//   - REC_BYTES     : bytes per record
// -----------------------------------------------------------------------------
package input_log_pkg;

    localparam int HDR_BYTES = 8;
    localparam int REC_BYTES = 8;
    localparam int REC_W     = REC_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } read_state_t;

    // Packed MSB-first: aux occupies bits 63:48, frame bits 15:0.
    typedef struct packed {
        logic [15:0] aux;
        logic [31:0] joy;
        logic [15:0] frame;
    } log_rec_t;

endpackage

// File: rtl/input_log_ram.sv
// -----------------------------------------------------------------------------
// input_log_ram
// Simple dual-port RAM, 2^DEPTH_LOG2 words of REC_W bits. One write port,
// one read port with a single registered read cycle. Contents are not reset.
// Ports:
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled on the rising edge
//   o_rdata  : read data, valid the cycle after i_raddr was presented
// -----------------------------------------------------------------------------
module input_log_ram
    import input_log_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [REC_W-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [REC_W-1:0]      o_rdata
);

    logic [REC_W-1:0] r_mem [1 << DEPTH_LOG2];
    logic [REC_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/input_log_uploader.sv
// -----------------------------------------------------------------------------
// input_log_uploader
// Records player-0 input changes, each stamped with a 16-bit frame counter,
// into a RAM log that the HPS can read back through the ioctl upload path.
//
// Ports:
//   clk_sys      : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   joystick     : player-0 digital buttons
//   analog       : player-0 analog stick {Y,X}; only used with the macro below
//   vblank       : vertical blank, rising edge advances the frame counter
//   clear        : one-cycle pulse emptying the log (ignored while frozen)
//   ioctl_upload : HPS upload session active
//   ioctl_index  : upload target index
//   ioctl_rd     : one-cycle read request
//   ioctl_addr   : read byte address
//   ioctl_din    : read data back to HPS
//   ioctl_wait   : high while a read is in flight
//   log_count    : number of valid records
//   overflow     : sticky, set when a record was dropped on a full log
//
// Configuration:
//   INPUT_LOG_ANALOG_EN defined   : analog goes into record bytes 6-7 and an
//                                   analog change also creates a record.
//   INPUT_LOG_ANALOG_EN undefined : bytes 6-7 are zero, analog is ignored.
// -----------------------------------------------------------------------------
module input_log_uploader #(
    parameter logic [7:0] UPLOAD_INDEX = 8'd2,
    parameter int         DEPTH_LOG2   = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [31:0]           joystick,
    input  logic [15:0]           analog,
    input  logic                  vblank,
    input  logic                  clear,
    input  logic                  ioctl_upload,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_rd,
    input  logic [24:0]           ioctl_addr,
    output logic [7:0]            ioctl_din,
    output logic                  ioctl_wait,
    output logic [DEPTH_LOG2:0]   log_count,
    output logic                  overflow
);

    import input_log_pkg::*;

    localparam int LC_W = DEPTH_LOG2 + 1;

    logic                  w_frozen;
    logic                  r_vblank_d;
    logic [15:0]           r_frame;
    logic [31:0]           r_joy_prev;
    logic                  w_change;
    log_rec_t              w_rec;
    logic [LC_W-1:0]       r_log_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_we;

    read_state_t           r_state;
    read_state_t           w_state_nxt;
    logic                  r_wait;
    logic                  w_wait_nxt;
    logic [7:0]            r_din;
    logic [7:0]            w_din_nxt;
    logic                  w_addr_ld;
    logic [24:0]           r_addr;
    logic [24:0]           w_off;
    logic [24:0]           w_rec_idx;
    logic                  w_in_log;
    logic [15:0]           w_cnt16;
    logic [REC_W-1:0]      w_rdata;
    logic [7:0]            w_rd_byte;

    assign w_frozen = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    // Count never exceeds 2^DEPTH_LOG2, so its MSB alone marks a full log.
    assign w_full = r_log_count[DEPTH_LOG2];

    // ---- Frame counter and previous-sample registers ----
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_d <= 1'b0;
            r_frame    <= 16'd0;
            r_joy_prev <= 32'd0;
        end else begin
            r_vblank_d <= vblank;
            if (vblank && !r_vblank_d) begin
                r_frame <= r_frame + 16'd1;
            end
            // Tracks every cycle, so changes made while frozen are dropped
            // rather than replayed when the upload ends.
            r_joy_prev <= joystick;
        end
    end

`ifdef INPUT_LOG_ANALOG_EN
    logic [15:0] r_ana_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ana_prev <= 16'd0;
        end else begin
            r_ana_prev <= analog;
        end
    end

    assign w_change  = (joystick != r_joy_prev) || (analog != r_ana_prev);
    assign w_rec.aux = analog;
`else
    logic w_unused_analog;
    assign w_unused_analog = ^analog;
    assign w_change  = (joystick != r_joy_prev);
    assign w_rec.aux = 16'h0000;
`endif

    assign w_rec.frame = r_frame;
    assign w_rec.joy   = joystick;

    // clear wins over a capture in the same cycle; both are inert while frozen.
    assign w_we = !w_frozen && !clear && w_change && !w_full;

    // ---- Capture: record count and overflow ----
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_log_count <= '0;
            r_overflow  <= 1'b0;
        end else if (!w_frozen) begin
            if (clear) begin
                r_log_count <= '0;
                r_overflow  <= 1'b0;
            end else if (w_change) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_log_count <= r_log_count + LC_W'(1);
                end
            end
        end
    end

    input_log_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (clk_sys),
        .i_we    (w_we),
        .i_waddr (r_log_count[DEPTH_LOG2-1:0]),
        .i_wdata (w_rec),
        .i_raddr (w_rec_idx[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    // ---- Read address decode (valid in DATA, RAM output already settled) ----
    assign w_off     = r_addr - 25'(HDR_BYTES);
    assign w_rec_idx = w_off >> $clog2(REC_BYTES);
    // The index compare uses the full address, so far addresses never alias
    // onto a real record through the truncated RAM address.
    assign w_in_log  = (r_addr >= 25'(HDR_BYTES)) && (w_rec_idx < 25'(r_log_count));
    assign w_cnt16   = 16'(r_log_count);

    always_comb begin
        w_rd_byte = 8'hFF;
        if (r_addr < 25'(HDR_BYTES)) begin
            case (r_addr[2:0])
                3'd0:    w_rd_byte = w_cnt16[7:0];
                3'd1:    w_rd_byte = w_cnt16[15:8];
                3'd2:    w_rd_byte = {7'b0, r_overflow};
                3'd3:    w_rd_byte = 8'(DEPTH_LOG2);
                default: w_rd_byte = 8'h00;
            endcase
        end else if (w_in_log) begin
            w_rd_byte = w_rdata[{r_addr[2:0], 3'b000} +: 8];
        end
    end

    // ---- Read FSM: next state and registered outputs ----
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_din_nxt   = r_din;
        w_addr_ld   = 1'b0;
        if (!w_frozen) begin
            // Session ended or retargeted: abandon any read, keep last data.
            w_state_nxt = ST_IDLE;
            w_wait_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ioctl_rd) begin
                        w_state_nxt = ST_FETCH;
                        w_wait_nxt  = 1'b1;
                        w_addr_ld   = 1'b1;
                    end
                end
                ST_FETCH: begin
                    w_state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    w_state_nxt = ST_IDLE;
                    w_din_nxt   = w_rd_byte;
                    w_wait_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_wait  <= 1'b0;
            r_din   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_din   <= w_din_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_addr_ld) begin
            r_addr <= ioctl_addr;
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign log_count  = r_log_count;
    assign overflow   = r_overflow;

endmodule
